pong_game_ctrl: RTL and testbench
=================================

Name: pong_game_ctrl

Overview:
- Game sequencer for the pong top level. Runs on the system clock beside the ball and paddle blocks.
- Decides when the ball is held centred and when it runs, and which side it serves toward.
- Counts points from ball-miss events, detects the winner, and drives the two 4-bit scores to the seven-segment controller.
- All delays are timed in video frames via a frame tick.

Parameters:
- WIN_SCORE, 9: points needed to win; legal range 1..9.
- SERVE_FRAMES, 60: frames the ball is held centred before each serve; >=1.
- POINT_FRAMES, 90: frames of pause after a point is scored; >=1.
- RESTART_FRAMES, 600: frames in OVER before auto-restart; used only with the optional feature.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  start button, active-high level, synchronous to clk.
- frame_tick  input  1  one-cycle pulse per video frame, synchronous to clk.
- miss_left  input  1  one-cycle pulse: ball passed the left paddle (point to player 2).
- miss_right  input  1  one-cycle pulse: ball passed the right paddle (point to player 1).
- ball_hold  output  1  1 = ball held at centre, motion frozen.
- ball_run  output  1  1 = ball moving.
- serve_dir  output  1  0 = serve toward left player, 1 = serve toward right player.
- score1  output  4  player 1 score, binary 0..WIN_SCORE.
- score2  output  4  player 2 score, binary 0..WIN_SCORE.
- game_over  output  1  high while in OVER.
- winner  output  1  0 = player 1, 1 = player 2; valid while game_over is high.
- state  output  3  current state encoding, for debug.

Behaviour:
- All outputs are registered. A triggering input changes state and outputs on the next clk edge, giving 1-cycle latency.
- Reset values: state=IDLE, ball_hold=1, ball_run=0, serve_dir=1, score1=score2=0, game_over=0, winner=0. Frame counter=0, start_q=1.
- start_q initialises to 1 so a button held through reset does not count as a press.
- A start press is start=1 && start_q==0; start_q is start delayed one cycle.
- States and encodings: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4. ball_run=1 only in PLAY; ball_hold=1 in every other state.
- The frame counter clears on every state entry and increments on frame_tick. A "done after N" condition fires on the frame_tick that takes the count to N.
- IDLE: a start press clears both scores and enters SERVE.
- SERVE: done after SERVE_FRAMES -> PLAY.
- PLAY, miss_left only: score2+1, serve_dir<=0 (serve toward the player who lost the point).
  - If the new score2 == WIN_SCORE -> OVER with winner<=1; otherwise -> POINT.
- PLAY, miss_right only: score1+1, serve_dir<=1; same win check, winner<=0.
- PLAY, miss_left and miss_right in the same cycle: no score change, serve_dir unchanged, -> SERVE (re-serve).
- POINT: done after POINT_FRAMES -> SERVE.
- OVER: game_over=1, scores frozen. A start press clears scores, sets serve_dir<=1, game_over<=0 -> SERVE.
- miss_* outside PLAY: ignored. start outside IDLE/OVER: ignored.
- Scores never exceed WIN_SCORE; no wrap-around.
- frame_tick coinciding with a state transition is not carried into the new state, because the counter clears on entry.
- Reset asserted mid-game: immediate return to reset values, regardless of clk.

Optional Feature:
- Macro: PONG_AUTO_RESTART_EN.
- Defined: in OVER, done after RESTART_FRAMES -> IDLE, with scores cleared and game_over<=0. A start press before expiry still goes directly to SERVE.
- Undefined: OVER persists until a start press; RESTART_FRAMES is unused.

Decomposition:
- pong_pkg holds:
  - typedef enum logic [2:0] game_state_t {IDLE, SERVE, PLAY, POINT, OVER};
  - SCORE_W=4;
  - a localparam helper for frame-counter width: $clog2 of the largest frame parameter, +1.
- One natural sub-module, pong_frame_timer:
  - inputs: clk, reset, clear, frame_tick, limit;
  - output: done, combinational on the terminal tick.
  - Instantiated once and shared by all states.

Test Plan (bench parameters: WIN_SCORE=3, SERVE_FRAMES=2, POINT_FRAMES=3, RESTART_FRAMES=4):
- Reset with start held high, then release and press start -> no transition while held; on the press, state 0->1 next cycle and ball_hold=1.
- In SERVE, 2 frame_ticks -> state=2, ball_run=1, ball_hold=0 one cycle after the 2nd tick.
- In PLAY, pulse miss_right -> score1=1, serve_dir=1, state=3. After 3 ticks -> SERVE; after 2 more -> PLAY.
- Drive miss_left three times through full point/serve cycles -> score2=3, state=4, game_over=1, winner=1. Further miss pulses leave score2=3.
- In PLAY, pulse miss_left and miss_right in the same cycle -> scores unchanged, serve_dir unchanged, state=1.
- In OVER with PONG_AUTO_RESTART_EN, 4 ticks -> state=0 and scores 0. Without the macro, 10 ticks -> still state=4; then a start press -> state=1 and scores 0.
- Assert reset mid-PLAY between clk edges -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and helpers for the pong game sequencer.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } game_state_t;

  localparam int SCORE_W = 4;

  // Frame counter must hold the largest frame limit, with one spare bit.
  function automatic int frame_cnt_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pong_frame_timer.sv
// Shared frame counter: clears on state entry, counts frame ticks, and flags
// the tick that brings the count to the current limit.
module pong_frame_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         frame_tick,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         cnt_max;

  assign cnt_max = (cnt_q == {W{1'b1}});

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (frame_tick && !cnt_max)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Saturated count never fires, so an unused zero limit stays quiet.
  assign done = frame_tick && !cnt_max && ((cnt_q + W'(1)) == limit);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve/play/point/over flow, scoring and winner.
// Optional auto-restart from OVER is enabled by defining PONG_AUTO_RESTART_EN.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE      = 9,
  parameter int SERVE_FRAMES   = 60,
  parameter int POINT_FRAMES   = 90,
  parameter int RESTART_FRAMES = 600
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               frame_tick,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic               ball_hold,
  output logic               ball_run,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               game_over,
  output logic               winner,
  output logic [2:0]         state
);

  localparam int FCW = frame_cnt_w(SERVE_FRAMES, POINT_FRAMES, RESTART_FRAMES);
  localparam logic [SCORE_W-1:0] WIN_S = SCORE_W'(WIN_SCORE);

  game_state_t        state_q, state_d;
  logic               start_q, start_d;
  logic               serve_dir_q, serve_dir_d;
  logic [SCORE_W-1:0] score1_q, score1_d;
  logic [SCORE_W-1:0] score2_q, score2_d;
  logic               winner_q, winner_d;
  logic               game_over_q, game_over_d;
  logic               ball_hold_q, ball_hold_d;
  logic               ball_run_q, ball_run_d;

  logic               start_press;
  logic               timer_clear;
  logic               timer_done;
  logic [FCW-1:0]     timer_limit;
  logic [SCORE_W-1:0] score1_inc, score2_inc;

  assign start_press = start && !start_q;
  assign score1_inc  = (score1_q >= WIN_S) ? score1_q : score1_q + SCORE_W'(1);
  assign score2_inc  = (score2_q >= WIN_S) ? score2_q : score2_q + SCORE_W'(1);

  always_comb begin
    timer_limit = '0;
    case (state_q)
      SERVE:   timer_limit = FCW'(SERVE_FRAMES);
      POINT:   timer_limit = FCW'(POINT_FRAMES);
      OVER:    timer_limit = FCW'(RESTART_FRAMES);
      default: timer_limit = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    serve_dir_d = serve_dir_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    winner_d    = winner_q;
    start_d     = start;

    case (state_q)
      IDLE: begin
        if (start_press) begin
          score1_d = '0;
          score2_d = '0;
          state_d  = SERVE;
        end
      end
      SERVE: begin
        if (timer_done) state_d = PLAY;
      end
      PLAY: begin
        if (miss_left && miss_right) begin
          state_d = SERVE;
        end else if (miss_left) begin
          score2_d    = score2_inc;
          serve_dir_d = 1'b0;
          if (score2_inc == WIN_S) begin
            state_d  = OVER;
            winner_d = 1'b1;
          end else begin
            state_d = POINT;
          end
        end else if (miss_right) begin
          score1_d    = score1_inc;
          serve_dir_d = 1'b1;
          if (score1_inc == WIN_S) begin
            state_d  = OVER;
            winner_d = 1'b0;
          end else begin
            state_d = POINT;
          end
        end
      end
      POINT: begin
        if (timer_done) state_d = SERVE;
      end
      OVER: begin
        if (start_press) begin
          score1_d    = '0;
          score2_d    = '0;
          serve_dir_d = 1'b1;
          state_d     = SERVE;
        end
`ifdef PONG_AUTO_RESTART_EN
        else if (timer_done) begin
          score1_d = '0;
          score2_d = '0;
          state_d  = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    ball_run_d  = (state_d == PLAY);
    ball_hold_d = (state_d != PLAY);
    game_over_d = (state_d == OVER);
  end

  // Any state change restarts frame timing, dropping a coincident tick.
  assign timer_clear = (state_d != state_q);

  pong_frame_timer #(
    .W(FCW)
  ) u_frame_timer (
    .clk        (clk),
    .reset      (reset),
    .clear      (timer_clear),
    .frame_tick (frame_tick),
    .limit      (timer_limit),
    .done       (timer_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      start_q     <= 1'b1;
      serve_dir_q <= 1'b1;
      score1_q    <= '0;
      score2_q    <= '0;
      winner_q    <= 1'b0;
      game_over_q <= 1'b0;
      ball_hold_q <= 1'b1;
      ball_run_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      serve_dir_q <= serve_dir_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      winner_q    <= winner_d;
      game_over_q <= game_over_d;
      ball_hold_q <= ball_hold_d;
      ball_run_q  <= ball_run_d;
    end
  end

  assign ball_hold = ball_hold_q;
  assign ball_run  = ball_run_q;
  assign serve_dir = serve_dir_q;
  assign score1    = score1_q;
  assign score2    = score2_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl with small frame parameters.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, frame_tick, miss_left, miss_right;
  logic       ball_hold, ball_run, serve_dir, game_over, winner;
  logic [3:0] score1, score2;
  logic [2:0] state;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct packed {
    logic [2:0] st;
    logic       hold;
    logic       run;
    logic       dir;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       over;
    logic       win;
  } exp_t;

  exp_t sb_q[$];

  pong_game_ctrl #(
    .WIN_SCORE      (3),
    .SERVE_FRAMES   (2),
    .POINT_FRAMES   (3),
    .RESTART_FRAMES (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .frame_tick (frame_tick),
    .miss_left  (miss_left),
    .miss_right (miss_right),
    .ball_hold  (ball_hold),
    .ball_run   (ball_run),
    .serve_dir  (serve_dir),
    .score1     (score1),
    .score2     (score2),
    .game_over  (game_over),
    .winner     (winner),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] st, input logic dir,
                              input logic [3:0] s1, input logic [3:0] s2,
                              input logic win);
    exp_t e;
    e.st   = st;
    e.hold = (st != 3'd2);
    e.run  = (st == 3'd2);
    e.dir  = dir;
    e.s1   = s1;
    e.s2   = s2;
    e.over = (st == 3'd4);
    e.win  = win;
    return e;
  endfunction

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 8'd1, 8'd0);
      return;
    end
    e = sb_q.pop_front();
    chk("state",     {5'd0, state},     {5'd0, e.st});
    chk("ball_hold", {7'd0, ball_hold}, {7'd0, e.hold});
    chk("ball_run",  {7'd0, ball_run},  {7'd0, e.run});
    chk("serve_dir", {7'd0, serve_dir}, {7'd0, e.dir});
    chk("score1",    {4'd0, score1},    {4'd0, e.s1});
    chk("score2",    {4'd0, score2},    {4'd0, e.s2});
    chk("game_over", {7'd0, game_over}, {7'd0, e.over});
    chk("winner",    {7'd0, winner},    {7'd0, e.win});
  endtask

  // Drive one cycle of inputs, expect the registered result after the edge.
  task automatic step(input logic st, input logic tk, input logic ml,
                      input logic mr, input exp_t e);
    start      = st;
    frame_tick = tk;
    miss_left  = ml;
    miss_right = mr;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic ticks(input int n, input exp_t mid, input exp_t last);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, (i == n - 1) ? last : mid);
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; frame_tick = 1'b0;
    miss_left = 1'b0; miss_right = 1'b0;
    #12;
    sb_q.push_back(mk(3'd0, 1'b1, 4'd0, 4'd0, 1'b0));
    compare_out();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // start held through reset is not a press
    step(1'b1, 1'b0, 1'b0, 1'b0, mk(3'd0, 1'b1, 4'd0, 4'd0, 1'b0));
    step(1'b1, 1'b0, 1'b0, 1'b0, mk(3'd0, 1'b1, 4'd0, 4'd0, 1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b0, mk(3'd0, 1'b1, 4'd0, 4'd0, 1'b0));
    step(1'b1, 1'b0, 1'b0, 1'b0, mk(3'd1, 1'b1, 4'd0, 4'd0, 1'b0));

    // serve: idle cycle between ticks does not advance
    step(1'b0, 1'b1, 1'b0, 1'b0, mk(3'd1, 1'b1, 4'd0, 4'd0, 1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b0, mk(3'd1, 1'b1, 4'd0, 4'd0, 1'b0));
    step(1'b0, 1'b1, 1'b0, 1'b0, mk(3'd2, 1'b1, 4'd0, 4'd0, 1'b0));

    // start ignored in PLAY, then point to player 1
    step(1'b1, 1'b0, 1'b0, 1'b0, mk(3'd2, 1'b1, 4'd0, 4'd0, 1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b1, mk(3'd3, 1'b1, 4'd1, 4'd0, 1'b0));
    ticks(3, mk(3'd3, 1'b1, 4'd1, 4'd0, 1'b0), mk(3'd1, 1'b1, 4'd1, 4'd0, 1'b0));
    ticks(2, mk(3'd1, 1'b1, 4'd1, 4'd0, 1'b0), mk(3'd2, 1'b1, 4'd1, 4'd0, 1'b0));

    // two points to player 2; a miss during POINT is ignored
    for (int k = 1; k <= 2; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, mk(3'd3, 1'b0, 4'd1, 4'(k), 1'b0));
      step(1'b0, 1'b0, 1'b1, 1'b0, mk(3'd3, 1'b0, 4'd1, 4'(k), 1'b0));
      ticks(3, mk(3'd3, 1'b0, 4'd1, 4'(k), 1'b0), mk(3'd1, 1'b0, 4'd1, 4'(k), 1'b0));
      ticks(2, mk(3'd1, 1'b0, 4'd1, 4'(k), 1'b0), mk(3'd2, 1'b0, 4'd1, 4'(k), 1'b0));
    end

    // simultaneous misses re-serve with no score or direction change
    step(1'b0, 1'b0, 1'b1, 1'b1, mk(3'd1, 1'b0, 4'd1, 4'd2, 1'b0));
    ticks(2, mk(3'd1, 1'b0, 4'd1, 4'd2, 1'b0), mk(3'd2, 1'b0, 4'd1, 4'd2, 1'b0));

    // winning point for player 2, later misses ignored
    step(1'b0, 1'b0, 1'b1, 1'b0, mk(3'd4, 1'b0, 4'd1, 4'd3, 1'b1));
    step(1'b0, 1'b0, 1'b1, 1'b0, mk(3'd4, 1'b0, 4'd1, 4'd3, 1'b1));
    step(1'b0, 1'b0, 1'b0, 1'b1, mk(3'd4, 1'b0, 4'd1, 4'd3, 1'b1));

`ifdef PONG_AUTO_RESTART_EN
    ticks(4, mk(3'd4, 1'b0, 4'd1, 4'd3, 1'b1), mk(3'd0, 1'b0, 4'd0, 4'd0, 1'b1));
    step(1'b1, 1'b0, 1'b0, 1'b0, mk(3'd1, 1'b0, 4'd0, 4'd0, 1'b1));
    ticks(2, mk(3'd1, 1'b0, 4'd0, 4'd0, 1'b1), mk(3'd2, 1'b0, 4'd0, 4'd0, 1'b1));
`else
    ticks(10, mk(3'd4, 1'b0, 4'd1, 4'd3, 1'b1), mk(3'd4, 1'b0, 4'd1, 4'd3, 1'b1));
    step(1'b1, 1'b0, 1'b0, 1'b0, mk(3'd1, 1'b1, 4'd0, 4'd0, 1'b1));
    ticks(2, mk(3'd1, 1'b1, 4'd0, 4'd0, 1'b1), mk(3'd2, 1'b1, 4'd0, 4'd0, 1'b1));
`endif
    step(1'b0, 1'b0, 1'b0, 1'b1, mk(3'd3, 1'b1, 4'd1, 4'd0, 1'b1));
    ticks(3, mk(3'd3, 1'b1, 4'd1, 4'd0, 1'b1), mk(3'd1, 1'b1, 4'd1, 4'd0, 1'b1));
    ticks(2, mk(3'd1, 1'b1, 4'd1, 4'd0, 1'b1), mk(3'd2, 1'b1, 4'd1, 4'd0, 1'b1));

    // asynchronous reset mid-PLAY, between clock edges
    #2;
    reset = 1'b1;
    #1;
    sb_q.push_back(mk(3'd0, 1'b1, 4'd0, 4'd0, 1'b0));
    compare_out();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 1'b0, 1'b0, mk(3'd0, 1'b1, 4'd0, 4'd0, 1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
